// File: rtl/sci_decode_pkg.sv
`default_nettype none
// sci_decode_pkg: BCD codes, active-low seven-segment patterns and FSM encodings.
package sci_decode_pkg;

  localparam logic [3:0] BCD_0 = 4'd0;
  localparam logic [3:0] BCD_1 = 4'd1;
  localparam logic [3:0] BCD_2 = 4'd2;
  localparam logic [3:0] BCD_3 = 4'd3;
  localparam logic [3:0] BCD_4 = 4'd4;
  localparam logic [3:0] BCD_5 = 4'd5;
  localparam logic [3:0] BCD_6 = 4'd6;
  localparam logic [3:0] BCD_7 = 4'd7;
  localparam logic [3:0] BCD_8 = 4'd8;
  localparam logic [3:0] BCD_9 = 4'd9;

  // Active-low, bit0 = segment a ... bit6 = segment g
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_E = 7'b0000110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MANT  = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sci_decode_seg_to_bcd.sv
`default_nettype none
// sci_decode_seg_to_bcd: inverse of the active-low seven-segment encoder.
// Any pattern other than 0-9 reports valid_o = 0.
module sci_decode_seg_to_bcd
  import sci_decode_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       valid_o
);

  always_comb begin
    bcd_o   = BCD_0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   bcd_o = BCD_0;
      SEG_1:   bcd_o = BCD_1;
      SEG_2:   bcd_o = BCD_2;
      SEG_3:   bcd_o = BCD_3;
      SEG_4:   bcd_o = BCD_4;
      SEG_5:   bcd_o = BCD_5;
      SEG_6:   bcd_o = BCD_6;
      SEG_7:   bcd_o = BCD_7;
      SEG_8:   bcd_o = BCD_8;
      SEG_9:   bcd_o = BCD_9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sci_decode.sv
`default_nettype none
// sci_decode: XXEY display digits -> binary XX * 10^Y via an iterative x10 datapath.
// Option SCI_DECODE_SEG_IN_EN: seven-segment inputs (plus seg_e) replace the BCD digits.
module sci_decode
  import sci_decode_pkg::*;
#(
  parameter int OUT_W = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SCI_DECODE_SEG_IN_EN
  input  logic [6:0]       seg_hi,
  input  logic [6:0]       seg_lo,
  input  logic [6:0]       seg_exp,
  input  logic [6:0]       seg_e,
`else
  input  logic [3:0]       dig_hi,
  input  logic [3:0]       dig_lo,
  input  logic [3:0]       dig_exp,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] value,
  output logic             err
);

  localparam int ACC_W = OUT_W + 4;

  state_e             state_q, state_d;
  logic [3:0]         hi_q, lo_q, exp_q, cnt_q;
  logic               bad_q, ovf_q, err_q;
  logic [ACC_W-1:0]   acc_q;
  logic [OUT_W-1:0]   value_q;

  logic [3:0]         w_hi, w_lo, w_exp;
  logic               w_bad, w_ovf;
  logic [ACC_W-1:0]   w_mant, w_step;

`ifdef SCI_DECODE_SEG_IN_EN
  logic w_v_hi, w_v_lo, w_v_exp;

  sci_decode_seg_to_bcd u_seg_hi  (.seg_i(seg_hi),  .bcd_o(w_hi),  .valid_o(w_v_hi));
  sci_decode_seg_to_bcd u_seg_lo  (.seg_i(seg_lo),  .bcd_o(w_lo),  .valid_o(w_v_lo));
  sci_decode_seg_to_bcd u_seg_exp (.seg_i(seg_exp), .bcd_o(w_exp), .valid_o(w_v_exp));

  assign w_bad = !w_v_hi || !w_v_lo || !w_v_exp || (seg_e != SEG_E);
`else
  assign w_hi  = dig_hi;
  assign w_lo  = dig_lo;
  assign w_exp = dig_exp;
  assign w_bad = (dig_hi > BCD_9) || (dig_lo > BCD_9) || (dig_exp > BCD_9);
`endif

  // x10 as shift-and-add; any bit at or above OUT_W marks sticky overflow
  assign w_mant = (ACC_W'(hi_q) << 3) + (ACC_W'(hi_q) << 1) + ACC_W'(lo_q);
  assign w_step = (acc_q << 3) + (acc_q << 1);
  assign w_ovf  = ovf_q || (|w_step[ACC_W-1:OUT_W]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_MANT;
      ST_MANT:  state_d = (bad_q || exp_q == BCD_0) ? ST_DONE : ST_SCALE;
      ST_SCALE: if (cnt_q == 4'd1) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= BCD_0;
      lo_q    <= BCD_0;
      exp_q   <= BCD_0;
      bad_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          hi_q  <= w_hi;
          lo_q  <= w_lo;
          exp_q <= w_exp;
          bad_q <= w_bad;
        end
        ST_MANT: begin
          acc_q <= w_mant;
          cnt_q <= exp_q;
          ovf_q <= 1'b0;
          if (bad_q) begin
            value_q <= '0;
            err_q   <= 1'b1;
          end else if (exp_q == BCD_0) begin
            value_q <= w_mant[OUT_W-1:0];
            err_q   <= 1'b0;
          end
        end
        ST_SCALE: begin
          acc_q <= w_step;
          cnt_q <= cnt_q - 4'd1;
          ovf_q <= w_ovf;
          if (cnt_q == 4'd1) begin
            value_q <= w_ovf ? '1 : w_step[OUT_W-1:0];
            err_q   <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign value = value_q;
  assign err   = err_q;

endmodule
`default_nettype wire
